// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB constants, slave FSM state type and the byte-lane mask helper for ahb_slave_mem.
package ahb_slave_mem_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Lanes touched by a transfer of 2^size bytes at addr within a bytes-wide word.
    function automatic logic [7:0] lane_mask(input logic [2:0] addr, input logic [2:0] size,
                                             input int unsigned bytes);
        logic [15:0] m;
        logic [2:0]  off;
        off = addr & 3'(bytes - 1);
        m   = (16'd1 << (16'd1 << size)) - 16'd1;
        m   = m << off;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Byte-writable word array: combinational read, strobed write committed at the clock edge.
// Zero-latency read, no backpressure; contents are never reset.
module ahb_slave_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int BYTES     = DATA_WIDTH / 8,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      strb,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (strb[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave memory with wait states and two-cycle ERROR; macro AHB_SLAVE_MEM_RAND_WAIT_EN randomises waits.
// Data phase takes 1 + wait cycles (0..7); backpressure is hready low during WAIT and ERR1.
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hrst,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [1:0]              htrans,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hstrb,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hready,
    output logic                    hresp
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int WORD_AW    = $clog2(MEM_DEPTH);

    state_t                state;
    logic [2:0]            wait_cnt;
    logic                  pending;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic       accept;
    logic       addr_err;
    logic       data_done;
    logic       mem_we;
    logic [7:0] lane;
    logic [7:0] align_mask;
    logic [2:0] wait_load;
    logic       unused_bits;

    assign accept     = hsel && htrans[1] && hready;
    assign align_mask = 8'((16'd1 << hsize) - 16'd1);
    assign addr_err   = ((haddr >> BYTE_SHIFT) >= ADDR_WIDTH'(MEM_DEPTH))
                     || (|(haddr[7:0] & align_mask))
                     || (hsize > 3'(BYTE_SHIFT));

    // pending is only ever set by a legal transfer, so hready high completes it.
    assign data_done = pending && hready;
    assign mem_we    = data_done && write_q;
    assign lane      = lane_mask(addr_q[2:0], size_q, BYTES);
    assign hrdata    = (data_done && !write_q) ? mem_rdata : hrdata_q;

    assign unused_bits = ^{hburst, htrans[0], addr_q, lane};

`ifdef AHB_SLAVE_MEM_RAND_WAIT_EN
    logic [7:0] lfsr;

    always_ff @(posedge hclk) begin
        if (hrst) begin
            lfsr <= 8'hA5;
        end else if (accept && !addr_err) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_load = 3'(int'(lfsr[2:0]) % (WAIT_STATES + 1));
`else
    assign wait_load = 3'(WAIT_STATES);
`endif

    ahb_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (hclk),
        .we    (mem_we),
        .addr  (addr_q[BYTE_SHIFT +: WORD_AW]),
        .wdata (hwdata),
        .strb  (hstrb & lane[BYTES-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            pending  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            hrdata_q <= '0;
            hready   <= 1'b1;
            hresp    <= HRESP_OKAY;
        end else begin
            if (data_done && !write_q) hrdata_q <= mem_rdata;

            if (accept) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                size_q  <= hsize;
                if (addr_err) begin
                    state   <= ST_ERR1;
                    pending <= 1'b0;
                    hready  <= 1'b0;
                    hresp   <= HRESP_ERROR;
                end else begin
                    pending <= 1'b1;
                    hresp   <= HRESP_OKAY;
                    if (wait_load != 3'd0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= wait_load;
                        hready   <= 1'b0;
                    end else begin
                        state  <= ST_IDLE;
                        hready <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (wait_cnt == 3'd1) begin
                            state  <= ST_IDLE;
                            hready <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 3'd1;
                        end
                    end
                    ST_ERR1: begin
                        state  <= ST_ERR2;
                        hready <= 1'b1;
                        hresp  <= HRESP_ERROR;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                        hready  <= 1'b1;
                        hresp   <= HRESP_OKAY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait instance and a three-wait instance share the bus inputs.
module tb_ahb_slave_mem;
    import ahb_slave_mem_pkg::*;

    logic        hclk = 1'b0;
    logic        hrst = 1'b1;
    logic        hsel0 = 1'b0;
    logic        hsel3 = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hwdata = '0;
    logic [3:0]  hstrb = 4'h0;

    logic [31:0] hrdata0, hrdata3;
    logic        hready0, hready3, hresp0, hresp3;

    int checks = 0;
    int passed = 0;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .hstrb(hstrb),
        .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
    );

    ahb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .hclk(hclk), .hrst(hrst), .hsel(hsel3), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .hstrb(hstrb),
        .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic s0, input logic s3, input logic [31:0] a, input logic wr,
                           input logic [2:0] sz, input logic [1:0] tr);
        hsel0  = s0;
        hsel3  = s3;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        htrans = tr;
    endtask

    task automatic idle_bus();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // Single zero-wait transfer on u_dut0; rd is hrdata seen in the data phase.
    task automatic xfer0(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd);
        addr_ph(1'b1, 1'b0, a, wr, sz, HTRANS_NONSEQ);
        tick();
        chk({tag, "_resp"}, {30'd0, hready0, hresp0}, 32'd2);
        rd     = hrdata0;
        hwdata = wd;
        hstrb  = st;
        idle_bus();
        tick();
    endtask

    task automatic err0(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz);
        addr_ph(1'b1, 1'b0, a, wr, sz, HTRANS_NONSEQ);
        tick();
        chk({tag, "_err1"}, {30'd0, hready0, hresp0}, 32'd1);
        hwdata = 32'hFFFF_FFFF;
        hstrb  = 4'hF;
        idle_bus();
        tick();
        chk({tag, "_err2"}, {30'd0, hready0, hresp0}, 32'd3);
        tick();
        chk({tag, "_after"}, {30'd0, hready0, hresp0}, 32'd2);
    endtask

    // Counts hready3-low cycles of the current data phase, bounded.
    task automatic wait_done3(output int n);
        n = 0;
        while (hready3 !== 1'b1 && n < 12) begin
            n++;
            tick();
        end
    endtask

    logic [31:0] rd;
    logic [31:0] wtab [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h0F1E_2D3C, 32'h4B5A_6978};
    int          n;

    initial begin
        tick();
        tick();
        hrst = 1'b0;
        chk("rst_resp0", {30'd0, hready0, hresp0}, 32'd2);
        chk("rst_rdata0", hrdata0, 32'h0);
        chk("rst_resp3", {30'd0, hready3, hresp3}, 32'd2);
        tick();

        // Pipelined write then read of the same word, one cycle each.
        addr_ph(1'b1, 1'b0, 32'h10, 1'b1, 3'd2, HTRANS_NONSEQ);
        tick();
        chk("wr_phase", {30'd0, hready0, hresp0}, 32'd2);
        hwdata = 32'hDEAD_BEEF;
        hstrb  = 4'hF;
        addr_ph(1'b1, 1'b0, 32'h10, 1'b0, 3'd2, HTRANS_NONSEQ);
        tick();
        chk("rd_phase", {30'd0, hready0, hresp0}, 32'd2);
        chk("rd_data", hrdata0, 32'hDEAD_BEEF);
        idle_bus();
        tick();
        chk("rd_hold", hrdata0, 32'hDEAD_BEEF);

        // Byte write is confined to its lane; a zero strobe writes nothing.
        xfer0("clr", 32'h10, 1'b1, 3'd2, 32'h0, 4'hF, rd);
        xfer0("byte", 32'h13, 1'b1, 3'd0, 32'h5511_1111, 4'hF, rd);
        xfer0("byte_rd", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd);
        chk("byte_data", rd, 32'h5500_0000);
        xfer0("nostrb", 32'h10, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'h0, rd);
        xfer0("nostrb_rd", 32'h10, 1'b0, 3'd2, 32'h0, 4'h0, rd);
        chk("nostrb_data", rd, 32'h5500_0000);

        // Illegal transfers: out of range, misaligned, oversized.
        xfer0("init0", 32'h0, 1'b1, 3'd2, 32'h1111_1111, 4'hF, rd);
        err0("range", 32'h1000, 1'b0, 3'd2);
        err0("misal", 32'h2, 1'b1, 3'd2);
        err0("oversz", 32'h8, 1'b1, 3'd3);
        xfer0("err_rd", 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, rd);
        chk("err_mem", rd, 32'h1111_1111);

        // BUSY is a no-access, zero-wait OKAY.
        addr_ph(1'b1, 1'b0, 32'h0, 1'b1, 3'd2, HTRANS_BUSY);
        tick();
        chk("busy_resp", {30'd0, hready0, hresp0}, 32'd2);
        hwdata = 32'hFFFF_FFFF;
        idle_bus();
        tick();
        xfer0("busy_rd", 32'h0, 1'b0, 3'd2, 32'h0, 4'h0, rd);
        chk("busy_mem", rd, 32'h1111_1111);

        // Three-wait instance: INCR4 write burst then INCR4 read burst.
        hburst = 3'b011;
        addr_ph(1'b0, 1'b1, 32'h0, 1'b1, 3'd2, HTRANS_NONSEQ);
        tick();
        for (int i = 0; i < 4; i++) begin
            hwdata = wtab[i];
            hstrb  = 4'hF;
            wait_done3(n);
            chk("wr4_waits", n, 32'd3);
            if (i < 3) addr_ph(1'b0, 1'b1, 32'(4 * (i + 1)), 1'b1, 3'd2, HTRANS_SEQ);
            else idle_bus();
            tick();
        end
        addr_ph(1'b0, 1'b1, 32'h0, 1'b0, 3'd2, HTRANS_NONSEQ);
        tick();
        for (int i = 0; i < 4; i++) begin
            wait_done3(n);
            chk("rd4_waits", n, 32'd3);
            chk("rd4_resp", {31'd0, hresp3}, 32'd0);
            chk("rd4_data", hrdata3, wtab[i]);
            if (i < 3) addr_ph(1'b0, 1'b1, 32'(4 * (i + 1)), 1'b0, 3'd2, HTRANS_SEQ);
            else idle_bus();
            tick();
        end
        hburst = 3'b000;

        // hsel drops after the address phase; the write still completes.
        addr_ph(1'b0, 1'b1, 32'h40, 1'b1, 3'd2, HTRANS_NONSEQ);
        tick();
        idle_bus();
        hwdata = 32'hCAFE_F00D;
        hstrb  = 4'hF;
        wait_done3(n);
        chk("seldrop_waits", n, 32'd3);
        tick();
        addr_ph(1'b0, 1'b1, 32'h40, 1'b0, 3'd2, HTRANS_NONSEQ);
        tick();
        idle_bus();
        wait_done3(n);
        chk("seldrop_data", hrdata3, 32'hCAFE_F00D);
        tick();

        // Reset during WAIT of a write drops it.
        addr_ph(1'b0, 1'b1, 32'h40, 1'b1, 3'd2, HTRANS_NONSEQ);
        tick();
        hwdata = 32'h1234_5678;
        idle_bus();
        tick();
        hrst = 1'b1;
        tick();
        hrst = 1'b0;
        tick();
        chk("rstw_resp", {30'd0, hready3, hresp3}, 32'd2);
        chk("rstw_rdata", hrdata3, 32'h0);
        addr_ph(1'b0, 1'b1, 32'h40, 1'b0, 3'd2, HTRANS_NONSEQ);
        tick();
        idle_bus();
        wait_done3(n);
        chk("rstw_waits", n, 32'd3);
        chk("rstw_mem", hrdata3, 32'hCAFE_F00D);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Single-port AHB slave memory model; the downstream consumer of the AHB master agent's signal bundle. The bench connects it as the DUT-side target.
- Decodes the pipelined address/data phases and applies byte-strobed writes to an internal array.
- Returns read data and inserts programmable wait states.
- Generates the two-cycle ERROR response for illegal transfers.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; legal values 32 or 64.
- MEM_DEPTH, 1024, number of DATA_WIDTH-wide words.
- WAIT_STATES, 0, fixed wait cycles inserted per non-error data phase; range 0..7.

Ports:
- hclk  in  1  bus clock; all logic on its rising edge.
- hrst  in  1  reset, synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size, log2 of bytes.
- hburst  in  3  burst type; informational only, not checked.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwdata  in  DATA_WIDTH  write data, valid in data phase.
- hstrb  in  DATA_WIDTH/8  byte-lane write strobes.
- hrdata  out  DATA_WIDTH  read data.
- hready  out  1  transfer done / slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (hrst=1 at an edge): hready=1, hresp=0, hrdata=0, state IDLE, wait counter 0, any pending phase discarded. Memory contents are not cleared.
- Address phase is accepted when hsel && htrans[1] && hready. On acceptance, latch haddr, hwrite and hsize into addr_q, write_q and size_q, and raise the pending flag.
- BUSY or IDLE with hready=1: no access. The next cycle is OKAY with zero wait.
- Error check at acceptance. An error is any of:
  - haddr/(DATA_WIDTH/8) >= MEM_DEPTH
  - haddr not aligned to 2^hsize
  - 2^hsize > DATA_WIDTH/8
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on error acceptance go to ERR1. On legal acceptance with WAIT_STATES>0, load the counter with WAIT_STATES and go to WAIT. With WAIT_STATES=0, the data phase completes in the next cycle from IDLE.
  - WAIT: hready=0 and the counter decrements each cycle. At 1, go to IDLE; the next cycle is the completing cycle with hready=1.
  - ERR1: hready=0, hresp=1, then go to ERR2.
  - ERR2: hready=1, hresp=1. No memory access. A new address phase may be accepted here.
- Data-phase completion (hready=1, pending, no error):
  - Write: for each lane i, mem[addr_q word] byte i <= hwdata byte i if hstrb[i] && lane_mask(addr_q, size_q)[i]. The commit happens at that edge.
  - Read: hrdata = mem[addr_q word] full word, driven from the array and latched address. A read immediately after a write to the same word returns the new data.
- hrdata holds its last value outside read completions. It is 0 after reset.
- Back-to-back: the next address phase is accepted in the same cycle that the previous data phase completes. Full pipelining gives 1 transfer/cycle at WAIT_STATES=0.
- hsel dropping mid data phase does not abort the current data phase.
- hrst asserted during WAIT or ERR1: pending write is dropped, memory is untouched, and the first cycle after reset release shows hready=1, hresp=0.

Optional Feature:
- Macro: AHB_SLAVE_MEM_RAND_WAIT_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'hA5 on reset, advances once per accepted legal transfer. Wait count per transfer = lfsr[2:0] mod (WAIT_STATES+1).
- Undefined: no LFSR; the wait count is exactly WAIT_STATES.

Decomposition:
- Package ahb_slave_mem_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants
  - HRESP_OKAY/ERROR constants
  - state enum typedef
  - lane_mask function (addr, size, bytes)
- One sub-module, ahb_slave_mem_array: byte-writable MEM_DEPTH x DATA_WIDTH array with async read and sync strobed write.

Test Plan:
- Reset release, then NONSEQ write of 32'hDEADBEEF at 0x10 (hsize=2, hstrb=4'hF), then read of 0x10 → hrdata=32'hDEADBEEF, hresp=0, one-cycle data phases at WAIT_STATES=0.
- Byte write of 8'h55 at 0x13 (hsize=0, hstrb=4'hF) to a word holding 32'h00000000 → readback 32'h55000000. Strobe 4'h0 leaves the word unchanged.
- Access at haddr=4*MEM_DEPTH, or hsize=2 at 0x2 → hready 0 then 1, hresp 1 for both cycles; memory unchanged.
- WAIT_STATES=3, INCR4 SEQ reads at 0x0..0xC → each data phase shows 3 hready=0 cycles; data in order.
- Write to 0x20 followed back-to-back by a read of 0x20 → the read returns the new data. An interleaved BUSY gives an OKAY zero-wait cycle.
- hrst during WAIT of a write to 0x40 → after release, hready=1, hresp=0, and mem[0x40] keeps its old value.
